// File: rtl/leaderboard_sequencer_pkg.sv
// Shared definitions for the leaderboard sequencer: FSM state encoding,
// score width, the empty-slot marker and the slot-address helper.
package leaderboard_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SCORE_WIDTH = 13;
  localparam logic [SCORE_WIDTH-1:0] EMPTY_SCORE = 13'h1FFF;

  // Register-file address of table slot idx; wraps in 3 bits like the RF port.
  function automatic logic [2:0] slot_addr(input logic [2:0] base, input logic [2:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/leaderboard_sequencer_if.sv
// Request/status and register-file port bundle of the leaderboard sequencer.
// master = game controller plus register file side, slave = sequencer.
interface leaderboard_sequencer_if
  import leaderboard_sequencer_pkg::*;
#(
  parameter int WIDTH = SCORE_WIDTH
);
  logic             InsertReq;
  logic [WIDTH-1:0] InsertScore;
  logic             ClearReq;
  logic             Busy;
  logic             Done;
  logic [2:0]       Rank;
  logic [2:0]       ReadAddr;
  logic [WIDTH-1:0] ReadData;
  logic             WriteEn;
  logic [2:0]       WriteAddr;
  logic [WIDTH-1:0] WriteData;

  modport master (
    output InsertReq, InsertScore, ClearReq, ReadData,
    input  Busy, Done, Rank, ReadAddr, WriteEn, WriteAddr, WriteData
  );

  modport slave (
    input  InsertReq, InsertScore, ClearReq, ReadData,
    output Busy, Done, Rank, ReadAddr, WriteEn, WriteAddr, WriteData
  );
endinterface

// File: rtl/leaderboard_sequencer_less_than13bit.sv
// Unsigned magnitude comparator: lt is high when a is strictly below b.
// Kept as its own block so other score logic can reuse it.
module leaderboard_sequencer_less_than13bit
  import leaderboard_sequencer_pkg::*;
#(
  parameter int WIDTH = SCORE_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt
);

  assign lt = (a < b);

endmodule

// File: rtl/leaderboard_sequencer.sv
// Keeps an ascending top-N table of best (lowest) reaction times in a shared
// register file. An insert walks the table once, one slot per cycle, carrying
// the larger value downward; a clear fills every slot with the empty marker.
module leaderboard_sequencer
  import leaderboard_sequencer_pkg::*;
#(
  parameter int               WIDTH     = SCORE_WIDTH,
  parameter int               TOP_N     = 3,
  parameter logic [2:0]       BASE_ADDR = 3'd1,
  parameter logic [WIDTH-1:0] EMPTY     = EMPTY_SCORE
) (
  input  logic                     Clock,
  input  logic                     CLRN,
  leaderboard_sequencer_if.slave   bus
);

  localparam logic [2:0] LAST_IDX = 3'(TOP_N - 1);

  state_e           state_r;
  logic [2:0]       idx_r;
  logic [WIDTH-1:0] carry_r;
  logic [2:0]       rank_r;
  logic             busy_r;
  logic             done_r;

  logic             lt_s;
  logic             swap_s;
  logic [2:0]       slot_s;
  logic [2:0]       read_addr_s;
  logic             write_en_s;
  logic [2:0]       write_addr_s;
  logic [WIDTH-1:0] write_data_s;

  assign slot_s = slot_addr(BASE_ADDR, idx_r);

  leaderboard_sequencer_less_than13bit #(.WIDTH(WIDTH)) u_lt (
    .a  (carry_r),
    .b  (bus.ReadData),
    .lt (lt_s)
  );

  // Register-file port decode: writes only in CLEAR and on a SCAN swap.
  always_comb begin
    read_addr_s  = 3'd0;
    write_en_s   = 1'b0;
    write_addr_s = 3'd0;
    write_data_s = '0;
    swap_s       = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        write_en_s   = 1'b1;
        write_addr_s = slot_s;
        write_data_s = EMPTY;
      end
      ST_SCAN: begin
        read_addr_s = slot_s;
        swap_s      = lt_s;
        if (lt_s) begin
          write_en_s   = 1'b1;
          write_addr_s = slot_s;
          write_data_s = carry_r;
        end else begin
          write_en_s   = 1'b0;
          write_addr_s = 3'd0;
          write_data_s = '0;
        end
      end
      default: begin
        read_addr_s  = 3'd0;
        write_en_s   = 1'b0;
        write_addr_s = 3'd0;
        write_data_s = '0;
        swap_s       = 1'b0;
      end
    endcase
  end

  // Sequencing FSM with registered Busy, Done and Rank.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      carry_r <= '0;
      rank_r  <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.ClearReq) begin
            idx_r   <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= ST_CLEAR;
          end else if (bus.InsertReq) begin
            carry_r <= bus.InsertScore;
            idx_r   <= 3'd0;
            rank_r  <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (idx_r == LAST_IDX) begin
            idx_r   <= 3'd0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        ST_SCAN: begin
          if (swap_s) begin
            carry_r <= bus.ReadData;
            if (rank_r == 3'd0) begin
              rank_r <= idx_r + 3'd1;
            end else begin
              rank_r <= rank_r;
            end
          end else begin
            carry_r <= carry_r;
          end
          if (idx_r == LAST_IDX) begin
            idx_r   <= 3'd0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          idx_r   <= 3'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Rank      = rank_r;
  assign bus.ReadAddr  = read_addr_s;
  assign bus.WriteEn   = write_en_s;
  assign bus.WriteAddr = write_addr_s;
  assign bus.WriteData = write_data_s;

endmodule

// File: tb/tb_leaderboard_sequencer.sv
// Scoreboard bench for leaderboard_sequencer with a behavioural 8x13 register
// file. Each operation pushes its expected outcome; a monitor checks it on Done.
module tb_leaderboard_sequencer;

  localparam int TOP_N = 3;

  typedef struct {
    string       name;
    logic [2:0]  rank;
    logic [38:0] table_v;
    int          writes;
  } exp_t;

  logic Clock;
  logic CLRN;
  logic [12:0] rf [8];

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   busy_cnt;
  int   wr_cnt;

  leaderboard_sequencer_if #(.WIDTH(13)) bus ();

  leaderboard_sequencer dut (
    .Clock (Clock),
    .CLRN  (CLRN),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Asynchronous-read, edge-written register file model.
  assign bus.ReadData = rf[bus.ReadAddr];
  always @(posedge Clock) begin
    if (bus.WriteEn) rf[bus.WriteAddr] <= bus.WriteData;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: counts Busy cycles and writes, checks the popped expectation on Done.
  always @(negedge Clock) begin
    if (!CLRN) begin
      busy_cnt = 0;
      wr_cnt   = 0;
    end else begin
      if (bus.Busy) busy_cnt++;
      if (bus.WriteEn) wr_cnt++;
      if (bus.Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_rank"}, 64'(bus.Rank), 64'(e.rank));
          check({e.name, "_table"}, 64'({rf[1], rf[2], rf[3]}), 64'(e.table_v));
          check({e.name, "_writes"}, 64'(wr_cnt), 64'(e.writes));
          check({e.name, "_latency"}, 64'(busy_cnt), 64'(TOP_N + 1));
        end
        busy_cnt = 0;
        wr_cnt   = 0;
      end
    end
  end

  task automatic push_exp(input string name, input logic [2:0] rank,
                          input logic [12:0] s1, input logic [12:0] s2,
                          input logic [12:0] s3, input int writes);
    exp_t e;
    e.name    = name;
    e.rank    = rank;
    e.table_v = {s1, s2, s3};
    e.writes  = writes;
    exp_q.push_back(e);
  endtask

  task automatic do_op(input logic clr, input logic ins, input logic [12:0] score);
    @(negedge Clock);
    bus.ClearReq    = clr;
    bus.InsertReq   = ins;
    bus.InsertScore = score;
    @(negedge Clock);
    bus.ClearReq  = 1'b0;
    bus.InsertReq = 1'b0;
    repeat (TOP_N + 2) @(negedge Clock);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    busy_cnt = 0;
    wr_cnt   = 0;
    CLRN     = 1'b0;
    bus.ClearReq    = 1'b0;
    bus.InsertReq   = 1'b0;
    bus.InsertScore = 13'd0;
    rf[0] = 13'h00AA; rf[1] = 13'h0123; rf[2] = 13'h0456; rf[3] = 13'h0789;
    rf[4] = 13'h0BBB; rf[5] = 13'h0CCC; rf[6] = 13'h0DDD; rf[7] = 13'h0EEE;

    // Reset state.
    #12;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_rank", 64'(bus.Rank), 64'd0);
    check("rst_ports", 64'({bus.ReadAddr, bus.WriteEn, bus.WriteAddr, bus.WriteData}), 64'd0);
    @(negedge Clock);
    CLRN = 1'b1;

    push_exp("clear", 3'd0, 13'h1FFF, 13'h1FFF, 13'h1FFF, 3);
    do_op(1'b1, 1'b0, 13'd0);
    push_exp("ins500", 3'd1, 13'd500, 13'h1FFF, 13'h1FFF, 1);
    do_op(1'b0, 1'b1, 13'd500);
    push_exp("ins300", 3'd1, 13'd300, 13'd500, 13'h1FFF, 2);
    do_op(1'b0, 1'b1, 13'd300);
    push_exp("ins400", 3'd2, 13'd300, 13'd400, 13'd500, 2);
    do_op(1'b0, 1'b1, 13'd400);
    push_exp("ins600", 3'd0, 13'd300, 13'd400, 13'd500, 0);
    do_op(1'b0, 1'b1, 13'd600);
    push_exp("tie400", 3'd3, 13'd300, 13'd400, 13'd400, 1);
    do_op(1'b0, 1'b1, 13'd400);
    push_exp("insempty", 3'd0, 13'd300, 13'd400, 13'd400, 0);
    do_op(1'b0, 1'b1, 13'h1FFF);
    push_exp("clr_prio", 3'd0, 13'h1FFF, 13'h1FFF, 13'h1FFF, 3);
    do_op(1'b1, 1'b1, 13'd50);

    // Insert 100, with a second insert pulsed while busy that must be dropped.
    push_exp("busy_drop", 3'd1, 13'd100, 13'h1FFF, 13'h1FFF, 1);
    @(negedge Clock);
    bus.InsertReq = 1'b1; bus.InsertScore = 13'd100;
    @(negedge Clock);
    bus.InsertReq = 1'b1; bus.InsertScore = 13'd50;
    @(negedge Clock);
    bus.InsertReq = 1'b0;
    repeat (TOP_N + 4) @(negedge Clock);
    check("no_pending", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a scan, while a write is being presented.
    @(negedge Clock);
    bus.InsertReq = 1'b1; bus.InsertScore = 13'd200;
    @(negedge Clock);
    bus.InsertReq = 1'b0;
    @(negedge Clock);
    check("pre_rst_we", 64'(bus.WriteEn), 64'd1);
    #2;
    CLRN = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.Busy), 64'd0);
    check("midrst_we", 64'(bus.WriteEn), 64'd0);
    repeat (2) @(negedge Clock);
    CLRN = 1'b1;
    #1;
    check("postrst_rank", 64'(bus.Rank), 64'd0);
    check("postrst_done", 64'(bus.Done), 64'd0);

    push_exp("reclear", 3'd0, 13'h1FFF, 13'h1FFF, 13'h1FFF, 3);
    do_op(1'b1, 1'b0, 13'd0);
    repeat (4) @(negedge Clock);
    check("final_pending", 64'(exp_q.size()), 64'd0);
    check("untouched", 64'({rf[0], rf[4], rf[7]}), 64'({13'h00AA, 13'h0BBB, 13'h0EEE}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
